// File: rtl/cache_pkg.sv
// Shared types and constants for the L1-miss to DRAM-controller request path.
package cache_pkg;

  localparam int LINE_W      = 128;
  localparam int DRAM_ADDR_W = 27;

  typedef enum logic {
    DRAM_WRITE = 1'b0,
    DRAM_READ  = 1'b1
  } dram_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DONE
  } line_req_state_t;

  // A 128-bit line spans eight 16-bit DRAM app words, hence the three zero LSBs.
  function automatic logic [DRAM_ADDR_W-1:0] line_to_app_addr(input logic [DRAM_ADDR_W-4:0] line_idx);
    return {line_idx, 3'b000};
  endfunction

endpackage

// File: rtl/dram_line_requester.sv
// Turns one L1 line miss into an optional victim write plus a line read on the DRAM FIFO link.
// Latency: miss handshake -> req_en next cycle; rsp_en -> done_valid next cycle.
// Backpressure: requests held until req_rdy; completion held until done_ready; one transaction in flight.
module dram_line_requester
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_W    = 24,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   miss_valid,
  output logic                   miss_ready,
  input  logic                   miss_fill,
  input  logic                   miss_dirty,
  input  logic [LINE_ADDR_W-1:0] miss_addr,
  input  logic [LINE_ADDR_W-1:0] victim_addr,
  input  logic [LINE_W-1:0]      victim_data,
  output logic                   req_en,
  input  logic                   req_rdy,
  output logic                   req_cmd,
  output logic [DRAM_ADDR_W-1:0] req_addr,
  output logic [LINE_W-1:0]      req_data,
  input  logic                   rsp_en,
  input  logic [LINE_W-1:0]      rsp_data,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [LINE_W-1:0]      done_data,
  output logic                   err_timeout,
  output logic                   err_spurious,
  output logic [CNT_W-1:0]       wb_count,
  output logic [CNT_W-1:0]       fill_count
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  if (LINE_ADDR_W + 3 != DRAM_ADDR_W) begin : g_addr_w_check
    $error("LINE_ADDR_W + 3 must equal DRAM_ADDR_W");
  end

  line_req_state_t state_q, state_d;
  logic req_en_q, req_en_d;

  logic                   cap_fill;
  logic                   cap_dirty;
  logic [LINE_ADDR_W-1:0] cap_miss_addr;
  logic [LINE_ADDR_W-1:0] cap_victim_addr;
  logic [LINE_W-1:0]      cap_victim_data;
  logic [TO_W-1:0]        to_cnt;

  logic miss_hs, req_hs, to_expire;

  assign miss_hs   = (state_q == ST_IDLE) && miss_valid;
  assign req_hs    = req_en_q && req_rdy;
  assign to_expire = (state_q == ST_RD_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign req_en    = req_en_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_en_q <= req_en_d;
    end
  end

  // req_en_d stays low for the cycle after any acceptance, which gives the WB->RD gap.
  always_comb begin
    state_d    = state_q;
    req_en_d   = 1'b0;
    miss_ready = 1'b0;
    done_valid = 1'b0;
    req_cmd    = DRAM_WRITE;
    req_addr   = '0;
    req_data   = '0;
    case (state_q)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          if (miss_dirty) begin
            state_d  = ST_WB_REQ;
            req_en_d = 1'b1;
          end else if (miss_fill) begin
            state_d  = ST_RD_REQ;
            req_en_d = 1'b1;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_WB_REQ: begin
        req_cmd  = DRAM_WRITE;
        req_addr = line_to_app_addr(cap_victim_addr);
        req_data = cap_victim_data;
        if (req_hs) state_d = cap_fill ? ST_RD_REQ : ST_DONE;
        else        req_en_d = 1'b1;
      end
      ST_RD_REQ: begin
        req_cmd  = DRAM_READ;
        req_addr = line_to_app_addr(cap_miss_addr);
        if (req_hs) state_d = ST_RD_WAIT;
        else        req_en_d = 1'b1;
      end
      ST_RD_WAIT: begin
        if (rsp_en) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_fill        <= 1'b0;
      cap_dirty       <= 1'b0;
      cap_miss_addr   <= '0;
      cap_victim_addr <= '0;
      cap_victim_data <= '0;
      done_data       <= '0;
      to_cnt          <= '0;
      err_timeout     <= 1'b0;
      err_spurious    <= 1'b0;
      wb_count        <= '0;
      fill_count      <= '0;
    end else begin
      if (miss_hs) begin
        cap_fill        <= miss_fill;
        cap_dirty       <= miss_dirty;
        cap_miss_addr   <= miss_addr;
        cap_victim_addr <= victim_addr;
        cap_victim_data <= victim_data;
        done_data       <= '0;
      end
      if (req_hs && state_q == ST_WB_REQ) wb_count <= wb_count + 1'b1;
      if (req_hs && state_q == ST_RD_REQ) to_cnt <= '0;
      if (state_q == ST_RD_WAIT) begin
        if (rsp_en) begin
          done_data  <= rsp_data;
          fill_count <= fill_count + 1'b1;
        end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else if (rsp_en) begin
        err_spurious <= 1'b1;
      end
      // A response landing on the expiry cycle is still accepted; the flag is set anyway.
      if (to_expire) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_line_requester.sv
// Directed-vector bench for dram_line_requester with a small FIFO-link request log.
module tb_dram_line_requester;
  import cache_pkg::*;

  localparam int LAW = 24;
  localparam int CW  = 32;

  logic            clk, rstn;
  logic            miss_valid, miss_ready, miss_fill, miss_dirty;
  logic [LAW-1:0]  miss_addr, victim_addr;
  logic [127:0]    victim_data;
  logic            req_en, req_rdy, req_cmd;
  logic [26:0]     req_addr;
  logic [127:0]    req_data;
  logic            rsp_en;
  logic [127:0]    rsp_data;
  logic            done_valid, done_ready;
  logic [127:0]    done_data;
  logic            err_timeout, err_spurious;
  logic [CW-1:0]   wb_count, fill_count;

  int n_vec = 0;
  int n_err = 0;
  logic [155:0] log_q[$];
  logic [155:0] ent;

  dram_line_requester #(.LINE_ADDR_W(LAW), .TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_fill(miss_fill),
    .miss_dirty(miss_dirty), .miss_addr(miss_addr), .victim_addr(victim_addr),
    .victim_data(victim_data),
    .req_en(req_en), .req_rdy(req_rdy), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data), .rsp_en(rsp_en), .rsp_data(rsp_data),
    .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
    .err_timeout(err_timeout), .err_spurious(err_spurious),
    .wb_count(wb_count), .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after posedge, so mid-cycle shows exactly what the next edge accepts.
  always @(negedge clk) begin
    if (rstn && req_en && req_rdy) log_q.push_back({req_cmd, req_addr, req_data});
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_miss(input logic fill, input logic dirty, input logic [LAW-1:0] a,
                            input logic [LAW-1:0] va, input logic [127:0] vd);
    miss_fill = fill; miss_dirty = dirty; miss_addr = a; victim_addr = va; victim_data = vd;
    miss_valid = 1'b1;
    cyc(1);
    miss_valid = 1'b0;
  endtask

  localparam logic [127:0] D1 = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
  localparam logic [127:0] V2 = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
  localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] V3 = 128'hCAFE_F00D_0000_0000_1234_5678_9ABC_DEF0;
  localparam logic [127:0] D4 = 128'h0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] D5 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

  initial begin
    rstn = 1'b0; miss_valid = 1'b0; miss_fill = 1'b0; miss_dirty = 1'b0;
    miss_addr = '0; victim_addr = '0; victim_data = '0;
    req_rdy = 1'b0; rsp_en = 1'b0; rsp_data = '0; done_ready = 1'b1;
    #12;
    chk("rst_req_en", 128'(req_en), 128'd0);
    chk("rst_done_valid", 128'(done_valid), 128'd0);
    chk("rst_done_data", done_data, 128'd0);
    chk("rst_errs", 128'({err_timeout, err_spurious}), 128'd0);
    chk("rst_counts", 128'({wb_count, fill_count}), 128'd0);
    chk("rst_miss_ready", 128'(miss_ready), 128'd1);
    rstn = 1'b1;
    cyc(1);

    // 1: clean fill
    log_q.delete();
    req_rdy = 1'b1;
    issue_miss(1'b1, 1'b0, 24'h000010, 24'h0, '0);
    chk("t1_req_en", 128'(req_en), 128'd1);
    chk("t1_req_cmd", 128'(req_cmd), 128'd1);
    chk("t1_req_addr", 128'(req_addr), 128'h0000080);
    chk("t1_miss_ready_busy", 128'(miss_ready), 128'd0);
    cyc(1);
    chk("t1_req_en_drop", 128'(req_en), 128'd0);
    cyc(4);
    rsp_en = 1'b1; rsp_data = D1;
    cyc(1);
    rsp_en = 1'b0;
    chk("t1_done_valid", 128'(done_valid), 128'd1);
    chk("t1_done_data", done_data, D1);
    chk("t1_fill_count", 128'(fill_count), 128'd1);
    chk("t1_wb_count", 128'(wb_count), 128'd0);
    cyc(1);
    chk("t1_idle_done_valid", 128'(done_valid), 128'd0);
    chk("t1_idle_miss_ready", 128'(miss_ready), 128'd1);
    chk("t1_nreq", 128'(log_q.size()), 128'd1);
    if (log_q.size() > 0) begin
      ent = log_q[0];
      chk("t1_log_cmd", 128'(ent[155]), 128'd1);
      chk("t1_log_addr", 128'(ent[154:128]), 128'h0000080);
    end

    // 2: dirty fill, request stalled for three cycles
    log_q.delete();
    req_rdy = 1'b0;
    issue_miss(1'b1, 1'b1, 24'h000030, 24'h000020, V2);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wr_en", 128'(req_en), 128'd1);
      chk("t2_wr_cmd", 128'(req_cmd), 128'd0);
      chk("t2_wr_addr", 128'(req_addr), 128'h0000100);
      chk("t2_wr_data", req_data, V2);
      if (i == 3) req_rdy = 1'b1;
      cyc(1);
    end
    chk("t2_gap", 128'(req_en), 128'd0);
    cyc(1);
    chk("t2_rd_en", 128'(req_en), 128'd1);
    chk("t2_rd_cmd", 128'(req_cmd), 128'd1);
    chk("t2_rd_addr", 128'(req_addr), 128'h0000180);
    chk("t2_rd_data", req_data, 128'd0);
    cyc(1);
    rsp_en = 1'b1; rsp_data = D2;
    cyc(1);
    rsp_en = 1'b0;
    chk("t2_done_valid", 128'(done_valid), 128'd1);
    chk("t2_done_data", done_data, D2);
    chk("t2_wb_count", 128'(wb_count), 128'd1);
    chk("t2_fill_count", 128'(fill_count), 128'd2);
    chk("t2_nreq", 128'(log_q.size()), 128'd2);
    cyc(1);

    // 3: writeback only
    log_q.delete();
    issue_miss(1'b0, 1'b1, 24'h000099, 24'h000040, V3);
    chk("t3_wr_en", 128'(req_en), 128'd1);
    cyc(1);
    chk("t3_done_valid", 128'(done_valid), 128'd1);
    chk("t3_done_data", done_data, 128'd0);
    cyc(3);
    chk("t3_nreq", 128'(log_q.size()), 128'd1);
    if (log_q.size() > 0) begin
      ent = log_q[0];
      chk("t3_log", 128'(ent), 128'({1'b0, 27'h0000200, V3}));
    end
    chk("t3_wb_count", 128'(wb_count), 128'd2);
    chk("t3_fill_count", 128'(fill_count), 128'd2);

    // 4: completion backpressure
    done_ready = 1'b0;
    issue_miss(1'b1, 1'b0, 24'h000055, 24'h0, '0);
    cyc(1);
    rsp_en = 1'b1; rsp_data = D4;
    cyc(1);
    rsp_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_done_valid", 128'(done_valid), 128'd1);
      chk("t4_done_data", done_data, D4);
      chk("t4_miss_ready", 128'(miss_ready), 128'd0);
      if (i == 3) done_ready = 1'b1;
      cyc(1);
    end
    chk("t4_released", 128'(done_valid), 128'd0);
    chk("t4_idle", 128'(miss_ready), 128'd1);
    chk("t4_fill_count", 128'(fill_count), 128'd3);

    // 5: read timeout, late response still completes
    issue_miss(1'b1, 1'b0, 24'h000077, 24'h0, '0);
    cyc(1);
    cyc(15);
    chk("t5_before_to", 128'(err_timeout), 128'd0);
    cyc(1);
    chk("t5_at_to", 128'(err_timeout), 128'd1);
    cyc(3);
    rsp_en = 1'b1; rsp_data = D5;
    cyc(1);
    rsp_en = 1'b0;
    chk("t5_done_valid", 128'(done_valid), 128'd1);
    chk("t5_done_data", done_data, D5);
    cyc(1);
    chk("t5_sticky", 128'(err_timeout), 128'd1);
    chk("t5_fill_count", 128'(fill_count), 128'd4);

    // 6: spurious response in IDLE
    chk("t6_pre", 128'(err_spurious), 128'd0);
    rsp_en = 1'b1; rsp_data = D1;
    cyc(1);
    rsp_en = 1'b0;
    chk("t6_spurious", 128'(err_spurious), 128'd1);
    chk("t6_still_idle", 128'(miss_ready), 128'd1);
    chk("t6_no_done", 128'(done_valid), 128'd0);
    chk("t6_fill_count", 128'(fill_count), 128'd4);
    chk("t6_done_data", done_data, D5);

    // 7: asynchronous reset while a read is outstanding
    issue_miss(1'b1, 1'b0, 24'h000099, 24'h0, '0);
    cyc(2);
    #2 rstn = 1'b0;
    #1;
    chk("t7_req_en", 128'(req_en), 128'd0);
    chk("t7_done_valid", 128'(done_valid), 128'd0);
    chk("t7_errs", 128'({err_timeout, err_spurious}), 128'd0);
    chk("t7_counts", 128'({wb_count, fill_count}), 128'd0);
    #3 rstn = 1'b1;
    cyc(1);
    chk("t7_miss_ready", 128'(miss_ready), 128'd1);
    rsp_en = 1'b1; rsp_data = D2;
    cyc(1);
    rsp_en = 1'b0;
    chk("t7_late_rsp", 128'(err_spurious), 128'd1);
    chk("t7_late_fill", 128'(fill_count), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
